// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared types, sizes and intra-nibble carry helper for the pipelined CLA
//
// Purpose: width constants, the generate/propagate pair type, the per-nibble
// G/P array type, and a flattened 4-bit carry function. The carry function is
// used by the second pipeline stage.
// Ports: none (package).

package cla_pkg;

    localparam int CLA_WIDTH = 32;
    localparam int CLA_NIB   = 8;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    typedef gp_t nib_gp_t [CLA_NIB];

    // Carry into each bit of a nibble, given the nibble carry-in c0.
    // Each term is written out as a sum of products, so no term waits on another.
    // Bit 3's generate is not needed here because the group generate already
    // covers the nibble carry-out.
    function automatic logic [3:0] nib_bit_carries(
        input logic [2:0] g,
        input logic [2:0] p,
        input logic       c0
    );
        logic [3:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

endpackage

// File: rtl/cla_nib_gp.sv
// rtl/cla_nib_gp.sv - combinational 4-bit slice generate/propagate terms
//
// Purpose: per-bit generate/propagate and group generate/propagate for one
// nibble of the operands.
// Ports:
//   i_a, i_b : 4-bit operand slices
//   o_g      : per-bit generate for bits 0..2
//              (bit 3 is absorbed into the group generate)
//   o_p      : per-bit propagate (a ^ b) for bits 0..3
//   o_grp    : group generate G and group propagate P

module cla_nib_gp
    import cla_pkg::*;
(
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [2:0] o_g,
    output logic [3:0] o_p,
    output gp_t        o_grp
);

    logic [3:0] w_g;
    logic [3:0] w_p;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    assign o_g = w_g[2:0];
    assign o_p = w_p;

    assign o_grp.g = w_g[3]
                   | (w_p[3] & w_g[2])
                   | (w_p[3] & w_p[2] & w_g[1])
                   | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign o_grp.p = &w_p;

endmodule

// File: rtl/cla32_pipe.sv
// rtl/cla32_pipe.sv - two-stage elastic pipelined 32-bit carry-lookahead adder
//
// Purpose: stage 1 registers the slice G/P terms, the per-bit g/p and cin.
// Stage 2 resolves the nibble carries with a flattened lookahead. It also forms
// the bit carries and registers sum/cout/ovf.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid, in_ready   : operand handshake (in_ready is combinational from out_ready)
//   a, b, cin            : operands and carry-in
//   out_valid, out_ready : result handshake
//   sum, cout, ovf       : a+b+cin low WIDTH bits, carry-out, signed overflow

module cla32_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Only WIDTH = 32 is supported; nib_gp_t is sized for that width.
    localparam int NIB = WIDTH / 4;

    // ---------------- handshake ----------------
    logic r_s1_valid;
    logic r_out_valid;
    logic w_s2_adv;
    logic w_s1_adv;

    assign w_s2_adv = !r_out_valid | out_ready;
    assign w_s1_adv = !r_s1_valid | w_s2_adv;
    assign in_ready = w_s1_adv;

    // ---------------- stage 1: slice G/P ----------------
    logic [3*NIB-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    nib_gp_t          w_grp;

    for (genvar k = 0; k < NIB; k++) begin : g_nib
        cla_nib_gp u_nib (
            .i_a   (a[4*k +: 4]),
            .i_b   (b[4*k +: 4]),
            .o_g   (w_g[3*k +: 3]),
            .o_p   (w_p[4*k +: 4]),
            .o_grp (w_grp[k])
        );
    end

    logic [3*NIB-1:0] r_s1_g;
    logic [WIDTH-1:0] r_s1_p;
    nib_gp_t          r_s1_grp;
    logic             r_s1_cin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_g     <= '0;
            r_s1_p     <= '0;
            r_s1_cin   <= 1'b0;
            for (int k = 0; k < NIB; k++) begin
                r_s1_grp[k] <= '0;
            end
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            // Data only loads on a real accept; a bubble leaves stale data behind the cleared valid.
            if (in_valid) begin
                r_s1_g   <= w_g;
                r_s1_p   <= w_p;
                r_s1_grp <= w_grp;
                r_s1_cin <= cin;
            end
        end
    end

    // ---------------- stage 2: lookahead and sum ----------------
    logic [NIB:0]     w_c;
    logic             w_acc;
    logic             w_pp;

    // c[k+1] = G[k] | P[k]G[k-1] | ... | P[k..0]cin. Every nibble carry is a
    // two-level term of the registered G/P, so no carry passes through another nibble.
    always_comb begin
        w_c    = '0;
        w_acc  = 1'b0;
        w_pp   = 1'b0;
        w_c[0] = r_s1_cin;
        for (int k = 0; k < NIB; k++) begin
            w_acc = r_s1_grp[k].g;
            w_pp  = r_s1_grp[k].p;
            for (int j = k - 1; j >= 0; j--) begin
                w_acc = w_acc | (w_pp & r_s1_grp[j].g);
                w_pp  = w_pp & r_s1_grp[j].p;
            end
            w_acc    = w_acc | (w_pp & r_s1_cin);
            w_c[k+1] = w_acc;
        end
    end

    logic [WIDTH-1:0] w_bc;

    always_comb begin
        w_bc = '0;
        for (int k = 0; k < NIB; k++) begin
            w_bc[4*k +: 4] = nib_bit_carries(r_s1_g[3*k +: 3], r_s1_p[4*k +: 3], w_c[k]);
        end
    end

    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;

    assign w_sum  = r_s1_p ^ w_bc;
    assign w_cout = w_c[NIB];
    assign w_ovf  = w_bc[WIDTH-1] ^ w_c[NIB];

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_cout;
                r_ovf  <= w_ovf;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_cla32_pipe.sv
// tb/tb_cla32_pipe.sv - directed self-checking bench for cla32_pipe

module tb_cla32_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    always #5 clk = ~clk;

    cla32_pipe #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_acc    = 0;
    int n_out    = 0;

    typedef struct packed {
        logic        cout;
        logic        ovf;
        logic [31:0] sum;
    } res_t;

    res_t exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic res_t model(input logic [31:0] ma, input logic [31:0] mb, input logic mc);
        logic [32:0] t;
        res_t        r;
        t      = {1'b0, ma} + {1'b0, mb} + {32'd0, mc};
        r.sum  = t[31:0];
        r.cout = t[32];
        r.ovf  = (ma[31] == mb[31]) && (t[31] != ma[31]);
        return r;
    endfunction

    // Scoreboard: records accepts and checks transfers at the falling edge.
    // Handshake signals are stable there.
    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            n_acc -= exp_q.size();
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                check("sb_spurious_out", 64'(exp_q.size() == 0), 64'd0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_result", 64'({cout, ovf, sum}), 64'(e));
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin));
                n_acc++;
            end
        end
    end

    // Called just after a rising edge with an empty pipeline.
    task automatic send_one(input string tag, input logic [31:0] ta, input logic [31:0] tb2,
                            input logic tc, input logic [31:0] es, input logic ec, input logic eo);
        a = ta; b = tb2; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_lat1_invalid"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_sum"},   64'(sum),  64'(es));
        check({tag, "_cout"},  64'(cout), 64'(ec));
        check({tag, "_ovf"},   64'(ovf),  64'(eo));
    endtask

    logic [31:0] va [6];
    logic [31:0] vb [6];

    initial begin
        int base;
        int k;
        int guard;

        va = '{32'h0000_0010, 32'h1234_5678, 32'hFFFF_0000, 32'h8000_0001, 32'h7FFF_0000, 32'hAAAA_AAAA};
        vb = '{32'h0000_0020, 32'h1111_1111, 32'h0001_0000, 32'h8000_0001, 32'h0001_0000, 32'h5555_5555};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_sum",       64'(sum),       64'd0);
        check("rst_cout",      64'(cout),      64'd0);
        check("rst_ovf",       64'(ovf),       64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        check("post_rst_sum",       64'(sum),       64'd0);

        // directed arithmetic
        send_one("basic",    32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
        send_one("prop",     32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        send_one("pos_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        send_one("neg_ovf",  32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        send_one("wrap",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        send_one("cin_ovf",  32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
        send_one("mixed",    32'h1234_5678, 32'h0FED_CBA9, 1'b1, 32'h2222_2222, 1'b0, 1'b0);
        @(posedge clk); #1;

        // back-to-back throughput
        base = n_out;
        for (int i = 0; i < 18; i++) begin
            if (i >= 2) check("tput_valid", 64'(out_valid), 64'd1);
            if (i < 16) begin
                a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        check("tput_drained", 64'(out_valid), 64'd0);
        check("tput_count",   64'(n_out - base), 64'd16);

        // backpressure
        base = n_out;
        k = 0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            a = va[k]; b = vb[k]; cin = 1'b0; in_valid = 1'b1;
            #1;
            if (cyc >= 2) begin
                check("bp_in_ready_low", 64'(in_ready),  64'd0);
                check("bp_hold_valid",   64'(out_valid), 64'd1);
                check("bp_hold_sum",     64'(sum),       64'h30);
            end
            if (in_ready) k++;
            @(posedge clk); #1;
        end
        check("bp_accepts", 64'(k), 64'd2);
        out_ready = 1'b1;
        guard = 0;
        while (k < 6 && guard < 20) begin
            a = va[k]; b = vb[k]; cin = 1'b0; in_valid = 1'b1;
            #1;
            if (in_ready) k++;
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        check("bp_all_sent", 64'(k), 64'd6);
        repeat (4) @(posedge clk);
        #1;
        check("bp_drain_count", 64'(n_out - base), 64'd6);

        // async reset with both stages full
        out_ready = 1'b0;
        a = 32'd1; b = 32'd1; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 32'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rst_mid_pre_valid", 64'(out_valid), 64'd1);
        check("rst_mid_pre_sum",   64'(sum),       64'd2);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_valid",    64'(out_valid), 64'd0);
        check("rst_mid_sum",      64'(sum),       64'd0);
        check("rst_mid_cout",     64'(cout),      64'd0);
        check("rst_mid_in_ready", 64'(in_ready),  64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_no_ghost", 64'(out_valid), 64'd0);
        send_one("post_rst", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty",      64'(exp_q.size()), 64'd0);
        check("sb_acc_vs_out", 64'(n_out),        64'(n_acc));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
